// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and a
// ceiling-log2 helper used to size owner and credit fields.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the write-port arbiter, bundled so
// the arbiter sees one slave port and the environment one master port.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);

    // Handshake: requester k offers a beat with i_req[k] (plus i_last[k] and
    // its data slice); the beat is taken in the cycle o_ack[k] is high, and
    // the producer advances to its next beat only after that cycle.
    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ-1:0]            i_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
    logic [NUM_REQ-1:0]            o_ack;
    logic                          i_fifo_pop;
    logic                          o_fifo_wen;
    logic [DATA_WIDTH-1:0]         o_fifo_wdata;

    modport slave (
        input  i_req, i_last, i_data, i_fifo_pop,
        output o_ack, o_fifo_wen, o_fifo_wdata
    );

    modport master (
        output i_req, i_last, i_data, i_fifo_pop,
        input  o_ack, o_fifo_wen, o_fifo_wdata
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: returns the first active request at or after
// i_ptr, wrapping around, by scanning a doubled request vector.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;
    logic                 found;

    always_comb begin
        dbl   = {i_req, i_req} >> i_ptr;
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && dbl[k]) begin
                off   = IDX_W'(k);
                found = 1'b1;
            end
        end
        // Offset is relative to the pointer; fold back into 0..NUM_REQ-1.
        sum = {1'b0, i_ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
        o_idx   = sum[IDX_W-1:0];
        o_valid = |i_req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter for a single FIFO write port, with a
// local credit counter so no write is issued into a full FIFO.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int OWN_W      = clog2(NUM_REQ),
    localparam int CRD_W      = clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fifo_wr_arbiter_if.slave   bus,
    output logic               o_busy,
    output logic [OWN_W-1:0]   o_owner,
    output logic [CRD_W-1:0]   o_credits,
    output arb_state_t         o_dbg_state
);

    localparam logic [CRD_W-1:0] FULL_CRD = CRD_W'(DEPTH);

    arb_state_t            state_q, state_d;
    logic [OWN_W-1:0]      owner_q, ptr_q, pick_idx, ptr_next;
    logic                  pick_valid, accept, own_req, own_last;
    logic [CRD_W-1:0]      credits_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q, own_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_picker (
        .i_req   (bus.i_req),
        .i_ptr   (ptr_q),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

    assign own_req  = bus.i_req[owner_q];
    assign own_last = bus.i_last[owner_q];
    assign own_data = bus.i_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_next = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Ownership lasts until the owner's last beat is accepted; a stalled
    // owner keeps the port indefinitely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid)          state_d = ST_BUSY;
            ST_BUSY: if (accept && own_last)  state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        bus.o_ack = '0;
        if (state_q == ST_BUSY) begin
            accept             = own_req && (credits_q != '0);
            bus.o_ack[owner_q] = accept;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && pick_valid)        owner_q <= pick_idx;
            if (state_q == ST_BUSY && accept && own_last) ptr_q  <= ptr_next;
        end
    end

    // A pop at full credit is a consumer error; saturate rather than wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_q <= FULL_CRD;
        end else begin
            case ({accept, bus.i_fifo_pop})
                2'b10:   credits_q <= credits_q - CRD_W'(1);
                2'b01:   if (credits_q != FULL_CRD) credits_q <= credits_q + CRD_W'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wen_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            wen_q <= accept;
            if (accept) wdata_q <= own_data;
        end
    end

    assign bus.o_fifo_wen   = wen_q;
    assign bus.o_fifo_wdata = wdata_q;
    assign o_busy           = (state_q == ST_BUSY);
    assign o_owner          = owner_q;
    assign o_credits        = credits_q;
    assign o_dbg_state      = state_q;

    pop_at_full_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(bus.i_fifo_pop && credits_q == FULL_CRD));

endmodule
